quick_spi_arbiter: RTL and testbench



---
 rtl/quick_spi_arbiter.sv | 149 ++++++++++++++
 tb/tb_quick_spi_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between NUM_REQUESTERS clients.
// Optional BUSY watchdog enabled by defining QUICK_SPI_ARBITER_TIMEOUT_EN.
module quick_spi_arbiter #(
  parameter int NUM_REQUESTERS      = 3,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int GAP_CYCLES          = 2,
  parameter int TIMEOUT_CYCLES      = 4096
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [NUM_REQUESTERS-1:0]                     req,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS-1:0]                     req_operation,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]                     grant,
  output logic [NUM_REQUESTERS-1:0]                     done,
  output logic                                          timeout,
  output logic [INCOMING_DATA_WIDTH-1:0]                rsp_data,
  output logic                                          spi_enable,
  output logic                                          spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
  output logic                                          spi_operation,
  output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
  input  logic                                          spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data
);

  localparam int PW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQUESTERS - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t                    state;
  logic [PW-1:0]             ptr;
  logic [PW-1:0]             winner;
  logic [PW:0]               idx;
  logic                      found;
  logic [NUM_REQUESTERS-1:0] win_onehot;
  logic [GW-1:0]             gap_cnt;

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] busy_cnt;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Scan clients starting at the pointer, wrapping; first requester wins.
  always_comb begin
    found      = 1'b0;
    winner     = '0;
    idx        = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_REQUESTERS)) idx = idx - (PW+1)'(NUM_REQUESTERS);
      if (!found && req[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
    win_onehot[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      ptr                   <= '0;
      gap_cnt               <= '0;
      grant                 <= '0;
      done                  <= '0;
      rsp_data              <= '0;
      spi_enable            <= 1'b1;
      spi_start_transaction <= 1'b0;
      spi_slave             <= '0;
      spi_operation         <= 1'b0;
      spi_outgoing_data     <= '0;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
      busy_cnt              <= '0;
      timeout_q             <= 1'b0;
`endif
    end else begin
      done                  <= '0;
      spi_start_transaction <= 1'b0;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
      timeout_q             <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            grant             <= win_onehot;
            spi_slave         <= req_slave[int'(winner)*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
            spi_operation     <= req_operation[winner];
            spi_outgoing_data <= req_data[int'(winner)*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
            ptr               <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            state             <= START;
          end
        end
        START: begin
          spi_start_transaction <= 1'b1;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
          busy_cnt              <= '0;
`endif
          state                 <= BUSY;
        end
        BUSY: begin
          // grant still holds the owner's one-hot, so it doubles as the done mask
          if (spi_end_of_transaction) begin
            rsp_data <= spi_incoming_data;
            done     <= grant;
            grant    <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
          else if (busy_cnt == TO_LAST) begin
            rsp_data   <= '0;
            done       <= grant;
            timeout_q  <= 1'b1;
            grant      <= '0;
            gap_cnt    <= '0;
            spi_enable <= 1'b0;
            state      <= GAP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            spi_enable <= 1'b1;
            state      <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Bench for quick_spi_arbiter: directed cases plus random traffic checked against a timestamp-based model.
module tb_quick_spi_arbiter;
  localparam int N  = 3;
  localparam int NS = 2;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int G  = 2;
  localparam int T  = 16;
`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*NS-1:0] req_slave;
  logic [N-1:0]    req_operation;
  logic [N*OW-1:0] req_data;
  logic [N-1:0]    grant, done;
  logic            timeout;
  logic [IW-1:0]   rsp_data;
  logic            spi_enable, spi_start_transaction, spi_operation;
  logic [NS-1:0]   spi_slave;
  logic [OW-1:0]   spi_outgoing_data;
  logic            spi_end_of_transaction;
  logic [IW-1:0]   spi_incoming_data;

  quick_spi_arbiter #(
    .NUM_REQUESTERS(N), .NUMBER_OF_SLAVES(NS), .INCOMING_DATA_WIDTH(IW),
    .OUTGOING_DATA_WIDTH(OW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_slave(req_slave),
    .req_operation(req_operation), .req_data(req_data), .grant(grant), .done(done),
    .timeout(timeout), .rsp_data(rsp_data), .spi_enable(spi_enable),
    .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
    .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;

  // Model: owner index plus timestamps of start, earliest next arbitration, and parking end.
  int            m_owner, m_ptr;
  longint        m_start_edge, m_free_at, m_park_end;
  logic [N-1:0]  m_grant, m_done;
  logic          m_to, m_start, m_en, m_op;
  logic [IW-1:0] m_rsp;
  logic [NS-1:0] m_slave;
  logic [OW-1:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_start_edge = 0; m_free_at = 0; m_park_end = 0;
    m_grant = '0; m_done = '0; m_to = 1'b0; m_start = 1'b0; m_en = 1'b1;
    m_rsp = '0; m_slave = '0; m_op = 1'b0; m_data = '0;
  endtask

  task automatic model_step();
    cyc++;
    m_done = '0; m_to = 1'b0; m_start = 1'b0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      if (cyc == m_start_edge) m_start = 1'b1;
      else if (cyc > m_start_edge) begin
        if (spi_end_of_transaction) begin
          m_done[m_owner] = 1'b1; m_rsp = spi_incoming_data;
          m_owner = -1; m_free_at = cyc + G + 1;
        end else if (TO_EN && (cyc - m_start_edge == T)) begin
          m_done[m_owner] = 1'b1; m_to = 1'b1; m_rsp = '0;
          m_owner = -1; m_free_at = cyc + G + 1; m_park_end = cyc + G;
        end
      end
    end else if (cyc >= m_free_at) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (m_owner < 0 && req[c]) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_ptr = (m_owner + 1) % N;
        m_slave = req_slave[m_owner*NS +: NS];
        m_op = req_operation[m_owner];
        m_data = req_data[m_owner*OW +: OW];
        m_start_edge = cyc + 1;
      end
    end
    m_grant = '0;
    if (m_owner >= 0) m_grant[m_owner] = 1'b1;
    m_en = (cyc >= m_park_end);
  endtask

  task automatic compare_all();
    chk("grant", 32'(grant), 32'(m_grant));
    chk("done", 32'(done), 32'(m_done));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
    chk("spi_enable", 32'(spi_enable), 32'(m_en));
    chk("spi_start", 32'(spi_start_transaction), 32'(m_start));
    chk("spi_slave", 32'(spi_slave), 32'(m_slave));
    chk("spi_operation", 32'(spi_operation), 32'(m_op));
    chk("spi_outgoing_data", 32'(spi_outgoing_data), 32'(m_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_client(input int c, input logic [NS-1:0] s, input logic op, input logic [OW-1:0] d);
    req_slave[c*NS +: NS] = s;
    req_operation[c] = op;
    req_data[c*OW +: OW] = d;
  endtask

  task automatic wait_start(output longint at);
    bit ok = 1'b0;
    at = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (spi_start_transaction) begin ok = 1'b1; at = cyc; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL wait_start: no spi_start_transaction within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic pulse_eot(input logic [IW-1:0] d);
    spi_incoming_data = d;
    spi_end_of_transaction = 1'b1;
    tick();
    spi_end_of_transaction = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    longint t_start, t_eot;
    int order [4] = '{0, 1, 2, 0};
    int busy_n;
    int rate;

    reset_n = 1'b0; req = '0; req_slave = '0; req_operation = '0; req_data = '0;
    spi_end_of_transaction = 1'b0; spi_incoming_data = '0;
    model_reset();
    repeat (2) tick();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_enable", 32'(spi_enable), 32'h1);
    chk("reset_rsp", 32'(rsp_data), 32'h0);
    chk("reset_start", 32'(spi_start_transaction), 32'h0);
    reset_n = 1'b1;

    // Single client write, latency and data stability
    set_client(0, 2'b10, 1'b1, 16'hA55A);
    req = 3'b001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_no_start_yet", 32'(spi_start_transaction), 32'h0);
    tick();
    chk("t1_start", 32'(spi_start_transaction), 32'h1);
    chk("t1_slave", 32'(spi_slave), 32'h2);
    chk("t1_data", 32'(spi_outgoing_data), 32'hA55A);
    req_data[15:0] = 16'hFFFF;
    repeat (3) tick();
    chk("t1_hold_data", 32'(spi_outgoing_data), 32'hA55A);
    pulse_eot(8'h55);
    req = '0;
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_rsp", 32'(rsp_data), 32'h55);

    // Read from client 2
    set_client(2, 2'b01, 1'b0, 16'h1234);
    req = 3'b100;
    wait_start(t_start);
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_op", 32'(spi_operation), 32'h0);
    tick();
    pulse_eot(8'h3C);
    req = '0;
    chk("t2_done", 32'(done), 32'h4);
    chk("t2_rsp", 32'(rsp_data), 32'h3C);
    tick();
    chk("t2_gap_grant", 32'(grant), 32'h0);

    // Fairness with all three held
    set_client(0, 2'b01, 1'b1, 16'h0A0A);
    set_client(1, 2'b10, 1'b0, 16'h0B0B);
    set_client(2, 2'b11, 1'b1, 16'h0C0C);
    req = 3'b111;
    t_eot = 0;
    for (int t = 0; t < 4; t++) begin
      wait_start(t_start);
      chk("fair_order", 32'(grant), 32'(1) << order[t]);
      if (t > 0) chk("fair_spacing_ok", 32'(t_start - t_eot >= G + 2), 32'h1);
      repeat (2) tick();
      pulse_eot(8'(t + 8'h10));
      t_eot = cyc;
      chk("fair_done", 32'(done), 32'(1) << order[t]);
    end

    // Async reset while busy
    wait_start(t_start);
    chk("rst_owner", 32'(grant), 32'h2);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_grant_now", 32'(grant), 32'h0);
    chk("rst_done_now", 32'(done), 32'h0);
    chk("rst_start_now", 32'(spi_start_transaction), 32'h0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    req = 3'b110;
    tick();
    chk("rst_ptr_zero", 32'(grant), 32'h2);
    chk("rst_no_done", 32'(done), 32'h0);
    wait_start(t_start);
    pulse_eot(8'h77);
    req = '0;

`ifdef QUICK_SPI_ARBITER_TIMEOUT_EN
    // Watchdog: no end_of_transaction
    set_client(0, 2'b01, 1'b0, 16'hBEEF);
    req = 3'b001;
    wait_start(t_start);
    busy_n = 0;
    for (int i = 0; i < 40 && done == '0; i++) begin
      tick();
      busy_n++;
    end
    req = '0;
    chk("to_busy_cycles", 32'(busy_n), 32'(T));
    chk("to_done", 32'(done), 32'h1);
    chk("to_flag", 32'(timeout), 32'h1);
    chk("to_rsp", 32'(rsp_data), 32'h0);
    chk("to_park0", 32'(spi_enable), 32'h0);
    tick();
    chk("to_park1", 32'(spi_enable), 32'h0);
    tick();
    chk("to_unpark", 32'(spi_enable), 32'h1);
`endif

    // Random traffic
    rate = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rate = (i / 500) % 3 == 0 ? 3 : ((i / 500) % 3 == 1 ? 8 : 30);
      for (int c = 0; c < N; c++) begin
        if (req[c]) begin
          if ($urandom_range(0, 15) == 0) req[c] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[c] = 1'b1;
          set_client(c, NS'($urandom), 1'($urandom), OW'($urandom));
        end
        if ($urandom_range(0, 7) == 0) req_data[c*OW +: OW] = OW'($urandom);
      end
      spi_end_of_transaction = ($urandom_range(0, rate - 1) == 0);
      spi_incoming_data = IW'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
